vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 25 ++
 rtl/wrap_counter.sv | 28 ++
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 raster constants and the shared counter width.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int H_TOTAL_D = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL_D = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    // Inclusive unsigned range test on a counter value.
    function automatic logic in_range(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that wraps from MAX to 0 and flags the wrap cycle.
module wrap_counter #(
    parameter int MAX   = 799,
    parameter int WIDTH = 10
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             enable,
    input  logic [WIDTH-1:0] rst_value,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

    assign wrap = enable && (count == MAX_C);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count <= rst_value;
        end else if (wrap) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: two wrap counters plus registered decodes taken
// from the counters' next values so every output describes the same pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_D,
    parameter int   H_FP     = H_FP_D,
    parameter int   H_SYNC   = H_SYNC_D,
    parameter int   H_BP     = H_BP_D,
    parameter int   V_ACTIVE = V_ACTIVE_D,
    parameter int   V_FP     = V_FP_D,
    parameter int   V_SYNC   = V_SYNC_D,
    parameter int   V_BP     = V_BP_D,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic [9:0]  hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        active_out,
    output logic        new_line_out,
    output logic        new_frame_out,
    output logic [15:0] frame_count_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] h_count, v_count;
    logic             h_wrap, v_wrap;

    wrap_counter #(.MAX(H_TOTAL - 1), .WIDTH(CNT_W)) u_h_counter (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .enable    (1'b1),
        .rst_value (H_LAST),
        .count     (h_count),
        .wrap      (h_wrap)
    );

    wrap_counter #(.MAX(V_TOTAL - 1), .WIDTH(CNT_W)) u_v_counter (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .enable    (h_wrap),
        .rst_value (V_LAST),
        .count     (v_count),
        .wrap      (v_wrap)
    );

    // Mirror of what the counters will hold after this edge.
    logic [CNT_W-1:0] h_next, v_next;
    logic             active_next, hsync_next, vsync_next;
    logic             line_next, frame_next;

    always_comb begin
        h_next      = h_wrap ? '0 : h_count + 1'b1;
        v_next      = v_count;
        if (v_wrap) begin
            v_next = '0;
        end else if (h_wrap) begin
            v_next = v_count + 1'b1;
        end
        active_next = (h_next < H_ACT_C) && (v_next < V_ACT_C);
        hsync_next  = in_range(h_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_next  = in_range(v_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
        line_next   = (h_next == '0);
        frame_next  = (h_next == '0) && (v_next == '0);
    end

    logic        active_q, hsync_q, vsync_q, line_q, frame_q;
    logic [15:0] frame_count_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_q        <= 1'b0;
            frame_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            active_q <= active_next;
            hsync_q  <= hsync_next;
            vsync_q  <= vsync_next;
            line_q   <= line_next;
            frame_q  <= frame_next;
            if (frame_next) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign hcount_out      = h_count;
    assign vcount_out      = v_count;
    assign hsync_out       = hsync_q;
    assign vsync_out       = vsync_q;
    assign active_out      = active_q;
    assign new_line_out    = line_q;
    assign new_frame_out   = frame_q;
    assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset and line timing, an 8x6-total
// instance for frame-level timing, mid-frame reset and frame counter wrap.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;

    logic [9:0]  m_h, m_v;
    logic        m_hs, m_vs, m_act, m_nl, m_nf;
    logic [15:0] m_fc;

    logic [9:0]  s_h, s_v;
    logic        s_hs, s_vs, s_act, s_nl, s_nf;
    logic [15:0] s_fc;

    int checks   = 0;
    int failures = 0;

    vga_timing_gen u_main (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .hcount_out      (m_h),
        .vcount_out      (m_v),
        .hsync_out       (m_hs),
        .vsync_out       (m_vs),
        .active_out      (m_act),
        .new_line_out    (m_nl),
        .new_frame_out   (m_nf),
        .frame_count_out (m_fc)
    );

    // Totals 8 x 6: hsync on h 5..6, vsync on v 4, visible 4 x 3.
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .hcount_out      (s_h),
        .vcount_out      (s_v),
        .hsync_out       (s_hs),
        .vsync_out       (s_vs),
        .active_out      (s_act),
        .new_line_out    (s_nl),
        .new_frame_out   (s_nf),
        .frame_count_out (s_fc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_main_reset(input string tag);
        check({tag, "_m_h"},   32'(m_h), 799);
        check({tag, "_m_v"},   32'(m_v), 524);
        check({tag, "_m_act"}, 32'(m_act), 0);
        check({tag, "_m_hs"},  32'(m_hs), 1);
        check({tag, "_m_vs"},  32'(m_vs), 1);
        check({tag, "_m_nl"},  32'(m_nl), 0);
        check({tag, "_m_nf"},  32'(m_nf), 0);
        check({tag, "_m_fc"},  32'(m_fc), 0);
    endtask

    task automatic check_small_reset(input string tag);
        check({tag, "_s_h"},   32'(s_h), 7);
        check({tag, "_s_v"},   32'(s_v), 5);
        check({tag, "_s_act"}, 32'(s_act), 0);
        check({tag, "_s_hs"},  32'(s_hs), 1);
        check({tag, "_s_vs"},  32'(s_vs), 1);
        check({tag, "_s_fc"},  32'(s_fc), 0);
    endtask

    initial begin
        int hs_low, act_hi, vs_low, act_f0, act_f1;
        int eh, ev;

        // Reset held with the clock running.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_main_reset("hold_rst");
        check_small_reset("hold_rst");

        // Release, run a few pixels, then pulse reset between edges.
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("run_m_h", 32'(m_h), 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_main_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release.
        @(negedge clk);
        check("first_m_h",  32'(m_h), 0);
        check("first_m_v",  32'(m_v), 0);
        check("first_m_act", 32'(m_act), 1);
        check("first_m_nl", 32'(m_nl), 1);
        check("first_m_nf", 32'(m_nf), 1);
        check("first_m_fc", 32'(m_fc), 1);

        // One full line of the 640x480 timing.
        hs_low = 0;
        act_hi = 0;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            if (!m_hs) hs_low++;
            if (m_act) act_hi++;
            case (i)
                1: begin
                    check("h1_nf", 32'(m_nf), 0);
                    check("h1_nl", 32'(m_nl), 0);
                    check("h1_fc", 32'(m_fc), 1);
                end
                639: check("h639_act", 32'(m_act), 1);
                640: begin
                    check("h640_h", 32'(m_h), 640);
                    check("h640_act", 32'(m_act), 0);
                end
                655: check("h655_hs", 32'(m_hs), 1);
                656: check("h656_hs", 32'(m_hs), 0);
                751: check("h751_hs", 32'(m_hs), 0);
                752: check("h752_hs", 32'(m_hs), 1);
                799: begin
                    check("h799_h", 32'(m_h), 799);
                    check("h799_v", 32'(m_v), 0);
                end
                800: begin
                    check("wrap_h",   32'(m_h), 0);
                    check("wrap_v",   32'(m_v), 1);
                    check("wrap_nl",  32'(m_nl), 1);
                    check("wrap_nf",  32'(m_nf), 0);
                    check("wrap_act", 32'(m_act), 1);
                end
                default: ;
            endcase
        end
        check("line_hsync_cycles", 32'(hs_low), 96);
        check("line_active_cycles", 32'(act_hi), 640);

        // Restart both instances for the small-raster frame checks.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_small_reset("async_rst2");
        @(negedge clk);
        rst_n = 1'b1;

        vs_low = 0;
        act_f0 = 0;
        act_f1 = 0;
        for (int c = 0; c <= 96; c++) begin
            @(negedge clk);
            eh = c % 8;
            ev = (c / 8) % 6;
            check("sm_h",   32'(s_h), 32'(eh));
            check("sm_v",   32'(s_v), 32'(ev));
            check("sm_act", 32'(s_act), 32'((eh < 4) && (ev < 3)));
            check("sm_hs",  32'(s_hs), 32'(!(eh == 5 || eh == 6)));
            check("sm_vs",  32'(s_vs), 32'(ev != 4));
            check("sm_nl",  32'(s_nl), 32'(eh == 0));
            check("sm_nf",  32'(s_nf), 32'(eh == 0 && ev == 0));
            check("sm_fc",  32'(s_fc), 32'(c / 48 + 1));
            if (c < 96 && !s_vs) vs_low++;
            if (c < 48 && s_act) act_f0++;
            if (c >= 48 && c < 96 && s_act) act_f1++;
        end
        check("sm_vsync_cycles", 32'(vs_low), 16);
        check("sm_active_f0", 32'(act_f0), 12);
        check("sm_active_f1", 32'(act_f1), 12);
        check("sm_third_frame_fc", 32'(s_fc), 3);

        // Reset in the middle of a visible line at (2,1).
        repeat (10) @(negedge clk);
        check("mid_s_h",   32'(s_h), 2);
        check("mid_s_v",   32'(s_v), 1);
        check("mid_s_act", 32'(s_act), 1);
        rst_n = 1'b0;
        #1;
        check_small_reset("mid_rst");
        check_main_reset("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_s_h",   32'(s_h), 0);
        check("restart_s_v",   32'(s_v), 0);
        check("restart_s_act", 32'(s_act), 1);
        check("restart_s_nf",  32'(s_nf), 1);
        check("restart_s_fc",  32'(s_fc), 1);
        check("restart_m_h",   32'(m_h), 0);
        check("restart_m_fc",  32'(m_fc), 1);

        // Frame counter wrap: preload 65535 mid-frame.
        @(negedge clk);
        force u_small.frame_count_q = 16'hffff;
        #1 release u_small.frame_count_q;
        check("preload_fc", 32'(s_fc), 65535);
        repeat (46) @(negedge clk);
        check("pre_wrap_h",  32'(s_h), 7);
        check("pre_wrap_v",  32'(s_v), 5);
        check("pre_wrap_fc", 32'(s_fc), 65535);
        @(negedge clk);
        check("wrap_s_nf", 32'(s_nf), 1);
        check("wrap_s_fc", 32'(s_fc), 0);
        @(negedge clk);
        check("post_wrap_nf", 32'(s_nf), 0);
        check("post_wrap_fc", 32'(s_fc), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
